// File: rtl/writeback_if.sv
// Writeback stage bus: MEM/WB register fields in, register-file write port out.
interface writeback_if #(
   parameter int DATA_W = 64,
   parameter int REG_W  = 5
);
   logic              Mem2Reg_WB;
   logic [REG_W-1:0]  RD_WB;
   logic [DATA_W-1:0] ALUout_WB;
   logic [DATA_W-1:0] ReadData_WB;
   logic [REG_W-1:0]  RD_ID;
   logic [DATA_W-1:0] MemtoRegOut_ID;

   // Upstream side: drives the MEM/WB fields, observes the register-file write port.
   modport master (
      output Mem2Reg_WB,
      output RD_WB,
      output ALUout_WB,
      output ReadData_WB,
      input  RD_ID,
      input  MemtoRegOut_ID
   );

   // Writeback stage itself.
   modport slave (
      input  Mem2Reg_WB,
      input  RD_WB,
      input  ALUout_WB,
      input  ReadData_WB,
      output RD_ID,
      output MemtoRegOut_ID
   );
endinterface

// File: rtl/writeback.sv
// Writeback stage: selects ALU result or load data and registers it, together
// with the destination index, toward the register-file write port.
// Write-enable gating lives outside this block; x0/XZR is not special-cased here.
module writeback #(
   parameter int DATA_W = 64,
   parameter int REG_W  = 5
) (
   input  logic         clk,
   input  logic         resetl,
   writeback_if.slave   wb
);

   logic [DATA_W-1:0] data_d, data_q;
   logic [REG_W-1:0]  rd_d, rd_q;

   // Full-width select between load data and ALU result; no extension or truncation.
   always_comb begin
      data_d = wb.ALUout_WB;
      rd_d   = wb.RD_WB;
      if (wb.Mem2Reg_WB) begin
         data_d = wb.ReadData_WB;
      end
   end

   // Output register; reset clears both outputs immediately and drops any in-flight value.
   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         data_q <= '0;
         rd_q   <= '0;
      end else begin
         data_q <= data_d;
         rd_q   <= rd_d;
      end
   end

   assign wb.MemtoRegOut_ID = data_q;
   assign wb.RD_ID          = rd_q;

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for the writeback stage: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_writeback;
   localparam int DATA_W = 64;
   localparam int REG_W  = 5;

   logic clk;
   logic resetl;
   int   n_tests;
   int   n_fail;

   writeback_if #(.DATA_W(DATA_W), .REG_W(REG_W)) wb_bus ();

   writeback #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
      .clk    (clk),
      .resetl (resetl),
      .wb     (wb_bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: the register-file port shows whatever the stage saw at
   // the last rising edge taken out of reset, or zero while/after reset.
   logic [REG_W-1:0]  exp_rd;
   logic [DATA_W-1:0] exp_data;

   function automatic logic [DATA_W-1:0] wb_value(input logic use_load,
                                                  input logic [DATA_W-1:0] alu,
                                                  input logic [DATA_W-1:0] load);
      return use_load ? load : alu;
   endfunction

   always @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         exp_rd   = '0;
         exp_data = '0;
      end else begin
         exp_rd   = wb_bus.RD_WB;
         exp_data = wb_value(wb_bus.Mem2Reg_WB, wb_bus.ALUout_WB, wb_bus.ReadData_WB);
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
      end
   endtask

   // Continuous comparison against the model, away from the active edge.
   always @(negedge clk) begin
      check("model_rd", 64'(wb_bus.RD_ID), 64'(exp_rd));
      check("model_data", wb_bus.MemtoRegOut_ID, exp_data);
      if (!resetl) begin
         check("reset_rd_zero", 64'(wb_bus.RD_ID), 64'd0);
         check("reset_data_zero", wb_bus.MemtoRegOut_ID, 64'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic m2r, input logic [REG_W-1:0] rd,
                        input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] load);
      wb_bus.Mem2Reg_WB  = m2r;
      wb_bus.RD_WB       = rd;
      wb_bus.ALUout_WB   = alu;
      wb_bus.ReadData_WB = load;
   endtask

   task automatic expect_out(input string name, input logic [REG_W-1:0] rd,
                             input logic [DATA_W-1:0] data);
      check({name, "_rd"}, 64'(wb_bus.RD_ID), 64'(rd));
      check({name, "_data"}, wb_bus.MemtoRegOut_ID, data);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      resetl  = 1'b0;
      drive(1'b0, 5'd9, 64'h55, 64'h0);

      // Reset held for two edges with nonzero inputs.
      tick();
      expect_out("reset_cyc1", 5'd0, 64'd0);
      tick();
      expect_out("reset_cyc2", 5'd0, 64'd0);

      // Load path; release between edges.
      #3;
      resetl = 1'b1;
      drive(1'b1, 5'd3, 64'd0, 64'd56);
      tick();
      expect_out("load_path", 5'd3, 64'd56);
      tick();
      expect_out("load_hold", 5'd3, 64'd56);

      // ALU path.
      drive(1'b0, 5'd7, 64'd98, 64'd0);
      tick();
      expect_out("alu_path", 5'd7, 64'd98);

      // Select isolation with latency check: new inputs must not show before the edge.
      drive(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF);
      #2;
      expect_out("latency_hold", 5'd7, 64'd98);
      tick();
      expect_out("sel_load", 5'd31, 64'h0123_4567_89AB_CDEF);
      wb_bus.Mem2Reg_WB = 1'b0;
      tick();
      expect_out("sel_alu", 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);

      // Asynchronous reset mid-stream.
      drive(1'b0, 5'd7, 64'd98, 64'd0);
      tick();
      expect_out("pre_reset", 5'd7, 64'd98);
      #2;
      resetl = 1'b0;
      #1;
      expect_out("async_clear", 5'd0, 64'd0);
      tick();
      expect_out("reset_over_edge", 5'd0, 64'd0);
      #2;
      resetl = 1'b1;
      tick();
      expect_out("post_release", 5'd7, 64'd98);

      // Register zero passes through unchanged.
      drive(1'b1, 5'd0, 64'h1111, 64'hDEAD_BEEF_0000_0001);
      tick();
      expect_out("rd_zero", 5'd0, 64'hDEAD_BEEF_0000_0001);

      // Back-to-back independent operations checked by the model each cycle.
      for (int i = 0; i < 40; i++) begin
         drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
               {$urandom, $urandom}, {$urandom, $urandom});
         tick();
      end

      // Short reset pulse inside a cycle during random traffic.
      #2;
      resetl = 1'b0;
      #2;
      expect_out("pulse_clear", 5'd0, 64'd0);
      resetl = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
               {$urandom, $urandom}, {$urandom, $urandom});
         tick();
      end

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
